// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared memory bus for coherent caches, with snoop broadcast and tenure pre-emption.
// Latency: grant one cycle after request is sampled; two-cycle grant-to-grant turnaround (RELEASE + IDLE).
// Backpressure: mem_hready low freezes pre-emption; the owner keeps the bus until its transfer completes.
module snoop_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int MAX_TENURE     = 16,
    localparam int ID_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int TW            = $clog2(MAX_TENURE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0]                 m_hreq,
    input  logic [NUM_MASTERS*ADDR_BUS_WIDTH-1:0]  m_haddr,
    input  logic [NUM_MASTERS-1:0]                 m_hwrite,
    output logic [NUM_MASTERS-1:0]                 m_hgrant,
    input  logic                                   mem_hready,
    output logic [ADDR_BUS_WIDTH-1:0]              mem_haddr,
    output logic                                   mem_hwrite,
    output logic                                   bus_busy,
    output logic [ID_W-1:0]                        owner_id,
    output logic [NUM_MASTERS-1:0]                 snoop_valid,
    output logic [ADDR_BUS_WIDTH-1:0]              snoop_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [1:0]                state;
    logic [ID_W-1:0]           rr_ptr;
    logic [TW-1:0]             tenure_cnt;
    logic [ADDR_BUS_WIDTH-1:0] hold_addr;
    logic                      hold_write;

    logic [ADDR_BUS_WIDTH-1:0] addr_arr [NUM_MASTERS];
    logic [ADDR_BUS_WIDTH-1:0] owner_addr;
    logic                      owner_write;
    logic                      owner_req;
    logic                      other_req;
    logic                      preempt;
    logic                      win_found;
    logic [ID_W-1:0]           win_idx;
    logic [ID_W-1:0]           cand;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_addr
        assign addr_arr[g] = m_haddr[g*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
    end

    assign owner_addr  = addr_arr[owner_id];
    assign owner_write = m_hwrite[owner_id];
    assign owner_req   = m_hreq[owner_id];
    assign other_req   = |(m_hreq & ~m_hgrant);

    // Only a tenure that has hit its limit yields, and never mid-transfer.
    assign preempt = (tenure_cnt == TW'(MAX_TENURE)) && other_req && mem_hready;

    // Scan starts just past the last owner and wraps modulo NUM_MASTERS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_MASTERS);
            if (!win_found && m_hreq[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= ID_W'(NUM_MASTERS - 1);
            owner_id   <= '0;
            m_hgrant   <= '0;
            tenure_cnt <= '0;
            hold_addr  <= '0;
            hold_write <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state      <= S_OWN;
                        m_hgrant   <= NUM_MASTERS'(1) << win_idx;
                        owner_id   <= win_idx;
                        rr_ptr     <= win_idx;
                        tenure_cnt <= '0;
                    end
                end
                S_OWN: begin
                    hold_addr  <= owner_addr;
                    hold_write <= owner_write;
                    if (!owner_req || preempt) begin
                        state    <= S_REL;
                        m_hgrant <= '0;
                    end else if (tenure_cnt != TW'(MAX_TENURE)) begin
                        tenure_cnt <= tenure_cnt + TW'(1);
                    end
                end
                S_REL: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    m_hgrant <= '0;
                end
            endcase
        end
    end

    // Memory and snoop side follow the owner live, and hold the last owner's values otherwise.
    assign bus_busy    = (state == S_OWN);
    assign mem_haddr   = bus_busy ? owner_addr : hold_addr;
    assign mem_hwrite  = bus_busy ? owner_write : hold_write;
    assign snoop_addr  = mem_haddr;
    assign snoop_valid = bus_busy ? ~m_hgrant : '0;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: per-cycle comparison against a behavioural model plus literal pins.
module tb_snoop_bus_arbiter;
    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int MAXT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  m_hreq = '0;
    logic [N*AW-1:0] m_haddr = '0;
    logic [N-1:0]  m_hwrite = '0;
    logic [N-1:0]  m_hgrant;
    logic          mem_hready = 1'b1;
    logic [AW-1:0] mem_haddr;
    logic          mem_hwrite;
    logic          bus_busy;
    logic [1:0]    owner_id;
    logic [N-1:0]  snoop_valid;
    logic [AW-1:0] snoop_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    snoop_bus_arbiter #(.NUM_MASTERS(N), .ADDR_BUS_WIDTH(AW), .MAX_TENURE(MAXT)) dut (
        .clk(clk), .rst(rst), .m_hreq(m_hreq), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
        .m_hgrant(m_hgrant), .mem_hready(mem_hready), .mem_haddr(mem_haddr),
        .mem_hwrite(mem_hwrite), .bus_busy(bus_busy), .owner_id(owner_id),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, how long they have held it, who had it last.
    int            md_own  = -1;
    int            md_last = 0;
    int            md_prio = N - 1;
    int            md_held = 0;
    bit            md_turn = 1'b0;
    logic [AW-1:0] md_addr = '0;
    logic          md_wr   = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            md_own = -1; md_last = 0; md_prio = N - 1; md_held = 0;
            md_turn = 1'b0; md_addr = '0; md_wr = 1'b0;
        end else if (md_own >= 0) begin
            bit others;
            md_addr = m_haddr[md_own*AW +: AW];
            md_wr   = m_hwrite[md_own];
            others  = 1'b0;
            for (int i = 0; i < N; i++)
                if (i != md_own && m_hreq[i]) others = 1'b1;
            if (!m_hreq[md_own] || (md_held >= MAXT && others && mem_hready)) begin
                md_own  = -1;
                md_turn = 1'b1;
            end else if (md_held < MAXT) begin
                md_held++;
            end
        end else if (md_turn) begin
            md_turn = 1'b0;
        end else if (m_hreq != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (md_prio + k) % N;
                if (m_hreq[c]) begin
                    md_own = c;
                    break;
                end
            end
            md_last = md_own;
            md_prio = md_own;
            md_held = 0;
        end
    end

    initial forever begin
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        @(negedge clk);
        eg = (md_own >= 0) ? N'(1 << md_own) : '0;
        ea = (md_own >= 0) ? m_haddr[md_own*AW +: AW] : md_addr;
        chk("m_hgrant", m_hgrant, eg);
        chk("bus_busy", bus_busy, md_own >= 0);
        chk("owner_id", owner_id, md_last);
        chk("snoop_valid", snoop_valid, (md_own >= 0) ? (~eg & 4'hF) : 4'h0);
        chk("mem_haddr", mem_haddr, ea);
        chk("snoop_addr", snoop_addr, ea);
        chk("grant_onehot0", $onehot0(m_hgrant), 1'b1);
        if (md_own >= 0) chk("mem_hwrite", mem_hwrite, m_hwrite[md_own]);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int idx);
        idx = -1;
        for (int c = 0; c < budget && idx < 0; c++) begin
            if (m_hgrant != '0) begin
                for (int i = 0; i < N; i++)
                    if (m_hgrant[i]) idx = i;
            end else begin
                step(1);
            end
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_grant no grant within %0d cycles t=%0t", budget, $time);
        end
    endtask

    // Master 1 owns; master 3 joins at tenure 5; optional memory stall over tenure 14..20.
    task automatic run_tenure(input bit stall, output int held);
        int t;
        t = 0;
        while (m_hgrant == 4'b0010 && t < 60) begin
            m_hreq[3] = (t >= 5);
            if (stall) mem_hready = !(t >= 14 && t <= 20);
            step(1);
            t++;
        end
        mem_hready = 1'b1;
        held = t;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        int idx, prev, held;
        for (int i = 0; i < N; i++) m_haddr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 16'h0100);
        step(2);
        chk("rst_grant", m_hgrant, 4'b0000);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_owner", owner_id, 2'd0);
        chk("rst_snoop", snoop_valid, 4'b0000);
        chk("rst_haddr", mem_haddr, 32'h0);
        chk("rst_hwrite", mem_hwrite, 1'b0);
        rst = 1'b0;

        // Single requester: grant one cycle later, release one cycle after drop.
        m_hreq = 4'b0100;
        #1 chk("t1_no_grant_yet", m_hgrant, 4'b0000);
        step(1);
        chk("t1_grant", m_hgrant, 4'b0100);
        chk("t1_owner", owner_id, 2'd2);
        chk("t1_snoop", snoop_valid, 4'b1011);
        step(4);
        m_hreq = 4'b0000;
        #1 chk("t1_still_held", m_hgrant, 4'b0100);
        step(1);
        chk("t1_released", m_hgrant, 4'b0000);
        chk("t1_busy_off", bus_busy, 1'b0);
        step(2);

        // All request; each drops after 3 owned cycles and re-requests.
        do_reset();
        m_hreq = 4'b1111;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(20, idx);
            chk("t2_order", idx, exp_order[g]);
            if (g > 0) chk("t2_spacing", cyc - prev, 5);
            prev = cyc;
            if (idx < 0) break;
            step(2);
            m_hreq[idx] = 1'b0;
            step(1);
            chk("t2_gap_grant", m_hgrant, 4'b0000);
            m_hreq[idx] = 1'b1;
        end
        m_hreq = '0;
        step(4);

        // Pre-emption at tenure 16.
        do_reset();
        m_hreq = 4'b0010;
        wait_grant(10, idx);
        chk("t3_first", idx, 1);
        run_tenure(1'b0, held);
        chk("t3_held", held, 17);
        wait_grant(10, idx);
        chk("t3_next", idx, 3);
        step(2);
        m_hreq[3] = 1'b0;
        step(1);
        wait_grant(10, idx);
        chk("t3_back", idx, 1);
        m_hreq = '0;
        step(3);

        // Pre-emption deferred while memory is busy.
        do_reset();
        m_hreq = 4'b0010;
        wait_grant(10, idx);
        chk("t4_first", idx, 1);
        run_tenure(1'b1, held);
        chk("t4_held", held, 22);
        wait_grant(10, idx);
        chk("t4_next", idx, 3);
        m_hreq = '0;
        step(3);

        // Asynchronous reset mid-tenure.
        do_reset();
        m_hreq = 4'b0100;
        wait_grant(10, idx);
        chk("t5_grant", idx, 2);
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_grant", m_hgrant, 4'b0000);
        chk("t5_async_snoop", snoop_valid, 4'b0000);
        chk("t5_async_busy", bus_busy, 1'b0);
        step(2);
        rst = 1'b0;
        m_hreq = 4'b1111;
        wait_grant(10, idx);
        chk("t5_after_rst", idx, 0);
        m_hreq = '0;
        step(3);

        // Address/write mux and snoop broadcast, plus hold after release.
        do_reset();
        m_haddr[2*AW +: AW] = 32'h0000_1A40;
        m_hwrite = 4'b0100;
        m_hreq = 4'b0100;
        wait_grant(10, idx);
        chk("t6_haddr", mem_haddr, 32'h0000_1A40);
        chk("t6_saddr", snoop_addr, 32'h0000_1A40);
        chk("t6_hwrite", mem_hwrite, 1'b1);
        chk("t6_snoop_self", snoop_valid[2], 1'b0);
        m_hreq = '0;
        step(1);
        m_haddr[2*AW +: AW] = 32'hFFFF_0000;
        #1 chk("t6_hold_addr", mem_haddr, 32'h0000_1A40);
        m_hwrite = '0;
        step(2);

        // Request dropped in the grant cycle still gets one owned cycle.
        do_reset();
        m_hreq = 4'b0001;
        step(1);
        chk("t7_grant", m_hgrant, 4'b0001);
        m_hreq = '0;
        step(1);
        chk("t7_release", m_hgrant, 4'b0000);
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
